// File: rtl/dct_pkg.sv
// Shared constants and helpers for the 4-point DCT-II datapath.
// The transform coefficients are kept here so every stage agrees on them.
package dct_pkg;

    localparam int C64 = 64;
    localparam int C83 = 83;
    localparam int C36 = 36;

    localparam int COEFF_W = 16;

    typedef logic signed [3:0][COEFF_W-1:0] coeff4_t;

    // Accumulator width: 8 bits of coefficient growth plus one for the odd-part sum.
    function automatic int acc_width(input int in_w);
        return in_w + 9;
    endfunction

endpackage

// File: rtl/dct4_odd_mult.sv
// Multiplierless constant products 36*o and 83*o for the odd DCT half.
// Output width W+7 holds 83*o exactly for any W-bit signed o.
module dct4_odd_mult
    import dct_pkg::*;
#(
    parameter int W = 20
) (
    input  logic signed [W-1:0] o,
    output logic signed [W+6:0] p36,
    output logic signed [W+6:0] p83
);

    logic signed [W+6:0] ox;

    assign ox = {{7{o[W-1]}}, o};

    // 36 = 32 + 4 and 83 = 64 + 16 + 2 + 1
    assign p36 = (ox <<< 5) + (ox <<< 2);
    assign p83 = (ox <<< 6) + (ox <<< 4) + (ox <<< 1) + ox;

endmodule

// File: rtl/dct2_4pt_pipe.sv
// Three-stage pipelined 4-point DCT-II with valid/ready handshake on both sides.
// Stages: butterfly, constant products, sum/round/clip into the output register.
module dct2_4pt_pipe
    import dct_pkg::*;
#(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16,
    parameter int SHIFT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x0,
    input  logic signed [IN_W-1:0]  x1,
    input  logic signed [IN_W-1:0]  x2,
    input  logic signed [IN_W-1:0]  x3,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] y0,
    output logic signed [OUT_W-1:0] y1,
    output logic signed [OUT_W-1:0] y2,
    output logic signed [OUT_W-1:0] y3,
    output logic                    out_last,
    output logic                    sat_flag,
    input  logic                    sat_clr
);

    localparam int E_W   = IN_W + 1;
    localparam int P_W   = IN_W + 8;
    localparam int ACC_W = acc_width(IN_W);
    localparam int E_SH  = $clog2(C64);

    localparam logic signed [ACC_W:0] BIAS     = (ACC_W+1)'(1 <<< (SHIFT-1));
    localparam logic signed [ACC_W:0] CLIP_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] CLIP_MIN = ~CLIP_MAX;

    logic en;

    logic                  s1_valid, s1_last;
    logic signed [E_W-1:0] e0_q, e1_q, o0_q, o1_q;
    logic signed [E_W-1:0] x0e, x1e, x2e, x3e;

    logic                  s2_valid, s2_last;
    logic signed [E_W:0]   even_sum, even_dif;
    logic signed [P_W-1:0] p36_0, p83_0, p36_1, p83_1;
    logic signed [P_W-1:0] pe0_q, pe2_q, p36_0_q, p83_0_q, p36_1_q, p83_1_q;

    logic signed [ACC_W-1:0] acc     [4];
    logic signed [ACC_W:0]   biased  [4];
    logic signed [ACC_W:0]   shifted [4];
    logic signed [OUT_W-1:0] clipped [4];
    logic                    sat_any;

    logic signed [OUT_W-1:0] y_q [4];

    // One global advance: the whole pipe stalls only when the output is held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign x0e = {x0[IN_W-1], x0};
    assign x1e = {x1[IN_W-1], x1};
    assign x2e = {x2[IN_W-1], x2};
    assign x3e = {x3[IN_W-1], x3};

    assign even_sum = {e0_q[E_W-1], e0_q} + {e1_q[E_W-1], e1_q};
    assign even_dif = {e0_q[E_W-1], e0_q} - {e1_q[E_W-1], e1_q};

    dct4_odd_mult #(.W(E_W)) u_odd0 (
        .o   (o0_q),
        .p36 (p36_0),
        .p83 (p83_0)
    );

    dct4_odd_mult #(.W(E_W)) u_odd1 (
        .o   (o1_q),
        .p36 (p36_1),
        .p83 (p83_1)
    );

    always_comb begin
        acc[0] = {pe0_q[P_W-1], pe0_q};
        acc[1] = {p83_0_q[P_W-1], p83_0_q} + {p36_1_q[P_W-1], p36_1_q};
        acc[2] = {pe2_q[P_W-1], pe2_q};
        acc[3] = {p36_0_q[P_W-1], p36_0_q} - {p83_1_q[P_W-1], p83_1_q};
    end

    // Round half up via bias then arithmetic shift, and saturate to the output range.
    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            biased[i]  = {acc[i][ACC_W-1], acc[i]} + BIAS;
            shifted[i] = biased[i] >>> SHIFT;
            if (shifted[i] > CLIP_MAX) begin
                clipped[i] = CLIP_MAX[OUT_W-1:0];
                sat_any    = 1'b1;
            end else if (shifted[i] < CLIP_MIN) begin
                clipped[i] = CLIP_MIN[OUT_W-1:0];
                sat_any    = 1'b1;
            end else begin
                clipped[i] = shifted[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            e0_q      <= '0;
            e1_q      <= '0;
            o0_q      <= '0;
            o1_q      <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            pe0_q     <= '0;
            pe2_q     <= '0;
            p36_0_q   <= '0;
            p83_0_q   <= '0;
            p36_1_q   <= '0;
            p83_1_q   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < 4; i++) y_q[i] <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_last   <= in_last;
            e0_q      <= x0e + x3e;
            e1_q      <= x1e + x2e;
            o0_q      <= x0e - x3e;
            o1_q      <= x1e - x2e;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            pe0_q     <= {even_sum, {E_SH{1'b0}}};
            pe2_q     <= {even_dif, {E_SH{1'b0}}};
            p36_0_q   <= p36_0;
            p83_0_q   <= p83_0;
            p36_1_q   <= p36_1;
            p83_1_q   <= p83_1;
            out_valid <= s2_valid;
            out_last  <= s2_last;
            for (int i = 0; i < 4; i++) y_q[i] <= clipped[i];
        end
    end

    // Clear wins over a simultaneous new saturation; held data never re-flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end else if (en && s2_valid && sat_any) begin
            sat_flag <= 1'b1;
        end
    end

    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];

endmodule

// File: tb/tb_dct2_4pt_pipe.sv
// Directed self-checking bench for dct2_4pt_pipe: latency, rounding, saturation,
// backpressure ordering and mid-flight reset, against a small integer reference model.
module tb_dct2_4pt_pipe;

    localparam int IN_W  = 19;
    localparam int OUT_W = 16;
    localparam int SHIFT = 1;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_last, sat_flag, sat_clr;
    logic signed [IN_W-1:0]  x0, x1, x2, x3;
    logic signed [OUT_W-1:0] y0, y1, y2, y3;

    int num_checks = 0;
    int num_errors = 0;

    typedef struct {
        longint y0;
        longint y1;
        longint y2;
        longint y3;
        logic   last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dct2_4pt_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_last  (out_last),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    task automatic check_output(input string tag, input longint observed, input longint expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint round_clip(input longint v);
        longint r;
        r = (v + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        if (r > 32767)  return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    function automatic exp_t model(input longint a, input longint b, input longint c,
                                   input longint d, input logic last);
        exp_t e;
        e.y0   = round_clip(64 * (a + b + c + d));
        e.y1   = round_clip(83 * (a - d) + 36 * (b - c));
        e.y2   = round_clip(64 * ((a + d) - (b + c)));
        e.y3   = round_clip(36 * (a - d) - 83 * (b - c));
        e.last = last;
        return e;
    endfunction

    // Present one vector for a single accepting edge; returns on the following negedge.
    task automatic apply_stimulus(input int a, input int b, input int c, input int d, input logic last);
        in_valid = 1'b1;
        x0 = IN_W'(a);
        x1 = IN_W'(b);
        x2 = IN_W'(c);
        x3 = IN_W'(d);
        in_last = last;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_single(input string tag, input int a, input int b, input int c, input int d,
                              input logic last, input int e0, input int e1, input int e2, input int e3,
                              input logic exp_sat);
        apply_stimulus(a, b, c, d, last);
        check_output($sformatf("%s_lat1", tag), out_valid, 0);
        @(negedge clk);
        check_output($sformatf("%s_lat2", tag), out_valid, 0);
        check_output($sformatf("%s_sat_pre", tag), sat_flag, 0);
        @(negedge clk);
        check_output($sformatf("%s_valid", tag), out_valid, 1);
        check_output($sformatf("%s_y0", tag), y0, e0);
        check_output($sformatf("%s_y1", tag), y1, e1);
        check_output($sformatf("%s_y2", tag), y2, e2);
        check_output($sformatf("%s_y3", tag), y3, e3);
        check_output($sformatf("%s_last", tag), out_last, last);
        check_output($sformatf("%s_sat", tag), sat_flag, exp_sat);
        @(negedge clk);
        check_output($sformatf("%s_drain", tag), out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        longint vec [6][4] = '{'{10, -20, 30, -40}, '{1000, 2000, -3000, 500}, '{-5, -5, -5, -5},
                               '{262143, -262144, 0, 7}, '{12345, -6789, 3, 0}, '{-1, 2, -3, 4}};
        logic   lasts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int     idx, n_out, cyc;
        exp_t   e;

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        repeat (2) @(negedge clk);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_y0", y0, 0);
        check_output("rst_sat", sat_flag, 0);
        check_output("rst_out_last", out_last, 0);
        check_output("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] impulse, dc and negative rounding");
        run_single("t1", 1, 0, 0, 0, 1'b1, 32, 42, 32, 18, 1'b0);
        run_single("t2", 100, 100, 100, 100, 1'b0, 12800, 0, 0, 0, 1'b0);
        run_single("t3", 0, 0, 0, -1, 1'b0, -32, 42, -32, 18, 1'b0);

        $display("[TB] saturation and sticky flag");
        run_single("t4", 262143, 262143, 262143, 262143, 1'b0, 32767, 0, 0, 0, 1'b1);
        check_output("t4_sat_held", sat_flag, 1);
        apply_stimulus(262143, 262143, 262143, 262143, 1'b0);
        @(negedge clk);
        check_output("t4_sat_before_clr", sat_flag, 1);
        sat_clr = 1'b1;
        @(negedge clk);
        check_output("t4_clr_valid", out_valid, 1);
        check_output("t4_clr_y0", y0, 32767);
        check_output("t4_clr_wins", sat_flag, 0);
        sat_clr = 1'b0;
        @(negedge clk);
        check_output("t4_sat_stays_clear", sat_flag, 0);

        $display("[TB] backpressure stream");
        idx = 0; n_out = 0; cyc = 0;
        while ((idx < 6 || n_out < 6) && cyc < 60) begin
            in_valid = (idx < 6);
            if (idx < 6) begin
                x0 = IN_W'(vec[idx][0]);
                x1 = IN_W'(vec[idx][1]);
                x2 = IN_W'(vec[idx][2]);
                x3 = IN_W'(vec[idx][3]);
                in_last = lasts[idx];
            end
            out_ready = !(cyc >= 4 && cyc < 9);
            #1;
            if (out_valid && !out_ready) check_output($sformatf("t5_stall_ready_c%0d", cyc), in_ready, 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_output($sformatf("t5_spurious_c%0d", cyc), out_valid, 0);
                end else begin
                    e = exp_q[0];
                    check_output($sformatf("t5_y0_v%0d", n_out), y0, e.y0);
                    check_output($sformatf("t5_y1_v%0d", n_out), y1, e.y1);
                    check_output($sformatf("t5_y2_v%0d", n_out), y2, e.y2);
                    check_output($sformatf("t5_y3_v%0d", n_out), y3, e.y3);
                    check_output($sformatf("t5_last_v%0d", n_out), out_last, e.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(vec[idx][0], vec[idx][1], vec[idx][2], vec[idx][3], lasts[idx]));
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_output("t5_outputs", n_out, 6);
        check_output("t5_queue_empty", exp_q.size(), 0);
        @(negedge clk);

        $display("[TB] reset with vectors in flight");
        for (int k = 0; k < 3; k++) apply_stimulus(k + 1, 0, 0, 0, 1'b1);
        check_output("t6_full", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_valid", out_valid, 0);
        check_output("t6_rst_y0", y0, 0);
        check_output("t6_rst_y1", y1, 0);
        check_output("t6_rst_y3", y3, 0);
        check_output("t6_rst_last", out_last, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("t6_post1", out_valid, 0);
        @(negedge clk);
        check_output("t6_post2", out_valid, 0);
        run_single("t6", 1, 0, 0, 0, 1'b0, 32, 42, 32, 18, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
